// File: rtl/text_layer_pkg.sv
// Shared types for the tile-text overlay: buffer cell layout, blank cell and clear FSM states.
package text_layer_pkg;

    typedef struct packed {
        logic [7:0]  ch;
        logic [11:0] color;
        logic        flash;
    } txt_cell_t;

    localparam txt_cell_t TXT_BLANK_CELL = '{ch: 8'h20, color: 12'h000, flash: 1'b0};

    typedef enum logic {
        TXT_IDLE  = 1'b0,
        TXT_CLEAR = 1'b1
    } txt_clr_state_t;

endpackage

// File: rtl/font.sv
// 8x8 glyph lookup: one bit per pixel, row 0 at the top, column 0 on the left (MSB of each row byte).
module font (
    input  logic [7:0] ch,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);
    logic [63:0] glyph;

    always_comb begin
        glyph = 64'h0;
        case (ch)
            8'h41:   glyph = 64'h183C_6666_7E66_6600;
            8'h42:   glyph = 64'h7C66_667C_6666_7C00;
            8'h58:   glyph = 64'h6666_3C18_3C66_6600;
            8'hDB:   glyph = 64'hFFFF_FFFF_FFFF_FFFF;
            default: glyph = 64'h0;
        endcase
    end

    assign pixel = glyph[6'd63 - {row, col}];

endmodule

// File: rtl/text_buffer_ram.sv
// Character cell buffer: one write port, one synchronous read port, read-first on collision.
module text_buffer_ram
    import text_layer_pkg::*;
#(
    parameter int DEPTH  = 1008,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  txt_cell_t         wdata,
    input  logic [ADDR_W-1:0] raddr,
    output txt_cell_t         rdata
);
    txt_cell_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_layer.sv
// Tile-text overlay: run-time writable character buffer rendered through the font with a
// 2-cycle pipeline, plus a buffer-clear engine and frame-synchronous flashing.
module text_layer
    import text_layer_pkg::*;
#(
    parameter int COLS         = 28,
    parameter int ROWS         = 36,
    parameter int SX_W         = 8,
    parameter int SY_W         = 9,
    parameter int ORIGIN_X     = 0,
    parameter int ORIGIN_Y     = 0,
    parameter int FLASH_FRAMES = 16,
    parameter int ADDR_W       = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SX_W-1:0]   sx,
    input  logic [SY_W-1:0]   sy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_char,
    input  logic [11:0]       wr_color,
    input  logic              wr_flash,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              busy,
    output logic [3:0]        R,
    output logic [3:0]        G,
    output logic [3:0]        B,
    output logic              pix_on
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = ((SX_W > SY_W) ? SX_W : SY_W) + 1;
    localparam int FC_W  = $clog2(FLASH_FRAMES + 1);

    txt_clr_state_t    state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TXT_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            TXT_IDLE: begin
                if (clr_req) begin
                    state_nx   = TXT_CLEAR;
                    clr_cnt_nx = '0;
                end
            end
            TXT_CLEAR: begin
                if (clr_cnt == ADDR_W'(CELLS - 1)) begin
                    state_nx = TXT_IDLE;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy     = (state == TXT_CLEAR);
    assign wr_ready = !busy;

    // The clear engine owns the write port while busy; host writes are dropped, not queued.
    logic              wr_in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    txt_cell_t         ram_wdata;

    assign wr_in_range = {1'b0, wr_addr} < (ADDR_W + 1)'(CELLS);
    assign ram_we      = busy || (wr_en && wr_in_range);
    assign ram_waddr   = busy ? clr_cnt : wr_addr;
    assign ram_wdata   = busy ? TXT_BLANK_CELL
                              : txt_cell_t'{ch: wr_char, color: wr_color, flash: wr_flash};

    // Offsets carry one extra bit so a pixel left of / above the origin shows up as negative.
    logic [CW:0]     dx, dy;
    logic            in_x, in_y;
    logic [ADDR_W:0] rd_addr_full;
    logic            in_area_q;
    logic [2:0]      fx_q, fy_q;
    txt_cell_t       rd_cell;

    assign dx   = (CW + 1)'(sx) - (CW + 1)'(ORIGIN_X);
    assign dy   = (CW + 1)'(sy) - (CW + 1)'(ORIGIN_Y);
    assign in_x = !dx[CW] && (dx[CW-1:0] < CW'(8 * COLS));
    assign in_y = !dy[CW] && (dy[CW-1:0] < CW'(8 * ROWS));
    assign rd_addr_full = (ADDR_W + 1)'(dy[CW-1:3]) * (ADDR_W + 1)'(COLS)
                        + (ADDR_W + 1)'(dx[CW-1:3]);

    text_buffer_ram #(
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ADDR_W'(rd_addr_full)),
        .rdata (rd_cell)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_area_q <= 1'b0;
            fx_q      <= '0;
            fy_q      <= '0;
        end else begin
            in_area_q <= in_x && in_y;
            fx_q      <= sx[2:0];
            fy_q      <= sy[2:0];
        end
    end

    // Frame strobe fires once on arrival at (0,0), however long it is held.
    logic            at_origin, at_origin_q, frame_strobe;
    logic [FC_W-1:0] frame_cnt;
    logic            phase;

    assign at_origin    = (sx == '0) && (sy == '0);
    assign frame_strobe = at_origin && !at_origin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin_q <= 1'b0;
            frame_cnt   <= '0;
            phase       <= 1'b1;
        end else begin
            at_origin_q <= at_origin;
            if (frame_strobe) begin
                if (frame_cnt == FC_W'(FLASH_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    phase     <= !phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    logic glyph_px, visible;

    font u_font (
        .ch    (rd_cell.ch),
        .row   (fy_q),
        .col   (fx_q),
        .pixel (glyph_px)
    );

    assign visible = in_area_q && glyph_px && (!rd_cell.flash || phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_on    <= 1'b0;
            {R, G, B} <= 12'h000;
        end else begin
            pix_on    <= visible;
            {R, G, B} <= visible ? rd_cell.color : 12'h000;
        end
    end

endmodule

// File: tb/tb_text_layer.sv
// Self-checking bench for text_layer: a screen-level model checked every cycle plus literal probes.
module tb_text_layer;
    localparam int COLS  = 28;
    localparam int ROWS  = 36;
    localparam int CELLS = COLS * ROWS;
    localparam int OX    = 0;
    localparam int OY    = 0;
    localparam int FF    = 2;
    localparam int OFF_X = 250;
    localparam int OFF_Y = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sx;
    logic [8:0]  sy;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_char;
    logic [11:0] wr_color;
    logic        wr_flash;
    logic        wr_ready;
    logic        clr_req;
    logic        busy;
    logic [3:0]  R, G, B;
    logic        pix_on;

    text_layer #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .SX_W         (8),
        .SY_W         (9),
        .ORIGIN_X     (OX),
        .ORIGIN_Y     (OY),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sx       (sx),
        .sy       (sy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .wr_color (wr_color),
        .wr_flash (wr_flash),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .busy     (busy),
        .R        (R),
        .G        (G),
        .B        (B),
        .pix_on   (pix_on)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Screen-level model state
    logic [7:0]  m_ch  [CELLS];
    logic [11:0] m_col [CELLS];
    logic        m_fl  [CELLS];
    bit          m_busy;
    int          clr_idx;
    int          frames;
    bit          at0_prev;
    logic        exp_pix;
    logic [11:0] exp_rgb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit glyph(input logic [7:0] ch, input int r, input int c);
        logic [7:0] rows [8];
        case (ch)
            8'h41:   rows = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
            8'h42:   rows = '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00};
            8'h58:   rows = '{8'h66, 8'h66, 8'h3C, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h00};
            8'hDB:   rows = '{default: 8'hFF};
            default: rows = '{default: 8'h00};
        endcase
        return rows[r][7-c];
    endfunction

    // One clock: advance the model by the edge just taken and compare every output.
    task automatic step();
        int          x, y, a;
        bit          at0, vis;
        logic        now_pix;
        logic [11:0] now_rgb;
        @(posedge clk);
        #1;
        x = int'(sx);
        y = int'(sy);
        if (rst) begin
            now_pix  = 1'b0;
            now_rgb  = 12'h000;
            exp_pix  = 1'b0;
            exp_rgb  = 12'h000;
            m_busy   = 1'b1;
            clr_idx  = 0;
            frames   = 0;
            at0_prev = 1'b0;
        end else begin
            now_pix = exp_pix;
            now_rgb = exp_rgb;
            at0 = (x == 0) && (y == 0);
            if (at0 && !at0_prev) frames++;
            at0_prev = at0;
            exp_pix = 1'b0;
            exp_rgb = 12'h000;
            if (x >= OX && x < OX + 8 * COLS && y >= OY && y < OY + 8 * ROWS) begin
                a   = ((y - OY) / 8) * COLS + (x - OX) / 8;
                vis = glyph(m_ch[a], (y - OY) % 8, (x - OX) % 8)
                      && (!m_fl[a] || ((frames / FF) % 2 == 0));
                exp_pix = vis;
                exp_rgb = vis ? m_col[a] : 12'h000;
            end
            if (m_busy) begin
                m_ch[clr_idx]  = 8'h20;
                m_col[clr_idx] = 12'h000;
                m_fl[clr_idx]  = 1'b0;
                if (clr_idx == CELLS - 1) m_busy = 1'b0;
                else clr_idx++;
            end else begin
                if (wr_en && int'(wr_addr) < CELLS) begin
                    m_ch[wr_addr]  = wr_char;
                    m_col[wr_addr] = wr_color;
                    m_fl[wr_addr]  = wr_flash;
                end
                if (clr_req) begin
                    m_busy  = 1'b1;
                    clr_idx = 0;
                end
            end
        end
        check("pix_on", pix_on, now_pix);
        check("rgb", {R, G, B}, now_rgb);
        check("busy", busy, m_busy);
        check("wr_ready", wr_ready, !m_busy);
    endtask

    task automatic write_cell(input int addr, input logic [7:0] ch, input logic [11:0] col, input logic fl);
        wr_en    = 1'b1;
        wr_addr  = 10'(addr);
        wr_char  = ch;
        wr_color = col;
        wr_flash = fl;
        step();
        wr_en = 1'b0;
    endtask

    task automatic probe(input int x, input int y, output logic pix, output logic [11:0] rgb);
        sx = 8'(x);
        sy = 9'(y);
        step();
        sx = 8'(OFF_X);
        sy = 9'(OFF_Y);
        step();
        pix = pix_on;
        rgb = {R, G, B};
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        p;
        logic [11:0] c;
        bit          vis_tbl [6];
        vis_tbl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < CELLS; i++) begin
            m_ch[i]  = 8'h20;
            m_col[i] = 12'h000;
            m_fl[i]  = 1'b0;
        end
        m_busy = 1'b1; clr_idx = 0; frames = 0; at0_prev = 1'b0;
        exp_pix = 1'b0; exp_rgb = 12'h000;
        rst = 1'b1; sx = 8'(OFF_X); sy = 9'(OFF_Y);
        wr_en = 1'b0; wr_addr = '0; wr_char = '0; wr_color = '0; wr_flash = 1'b0; clr_req = 1'b0;

        // Reset release: busy for the full buffer length while the screen is scanned
        repeat (3) step();
        rst = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            sx = 8'(n % 256);
            sy = 9'((n * 7) % 300);
            n++;
            step();
        end
        check("reset_busy_cycles", n, 1008);
        check("ready_after_clear", wr_ready, 1'b1);
        for (int y = 0; y < 300; y += 5) begin
            for (int x = 0; x < 256; x += 3) begin
                sx = 8'(x);
                sy = 9'(y);
                step();
            end
        end

        // Single glyph: 'A' red at row 1 col 1
        sx = 8'(OFF_X); sy = 9'(OFF_Y);
        write_cell(29, 8'h41, 12'hF00, 1'b0);
        for (int y = 8; y < 16; y++) begin
            for (int x = 8; x < 16; x++) begin
                sx = 8'(x);
                sy = 9'(y);
                step();
            end
        end
        sx = 8'(OFF_X); sy = 9'(OFF_Y);
        step(); step();
        probe(11, 8, p, c);
        check("a_on_pixel_rgb", c, 12'hF00);
        probe(8, 8, p, c);
        check("a_off_pixel", p, 1'b0);
        probe(16, 8, p, c);
        check("neighbour_blank", p, 1'b0);
        sx = 8'd11; sy = 9'd8;
        step();
        sx = 8'(OFF_X); sy = 9'(OFF_Y);
        check("latency_1cyc", pix_on, 1'b0);
        step();
        check("latency_2cyc", pix_on, 1'b1);

        // Area boundaries
        write_cell(27, 8'hDB, 12'h0F0, 1'b0);
        probe(223, 3, p, c);
        check("last_col_rgb", c, 12'h0F0);
        probe(224, 3, p, c);
        check("past_right_edge", p, 1'b0);
        write_cell(980, 8'hDB, 12'h00F, 1'b0);
        probe(0, 287, p, c);
        check("last_row_rgb", c, 12'h00F);
        probe(0, 288, p, c);
        check("past_bottom_edge", p, 1'b0);

        // Flash: fresh reset so the frame counter starts at zero
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        wait_clear(n);
        check("clear_after_reset2", n, 1008);
        write_cell(0, 8'h58, 12'hFFF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            probe(1, 1, p, c);
            check($sformatf("flash_frame%0d", k), p, vis_tbl[k]);
            sx = 8'd0; sy = 9'd0;
            repeat ((k == 0) ? 5 : 1) step();
            sx = 8'(OFF_X); sy = 9'(OFF_Y);
            step();
        end

        // Clear while writing: dropped write, re-pulsed clr_req ignored
        write_cell(5, 8'h42, 12'hFFF, 1'b0);
        probe(41, 0, p, c);
        check("b_before_clear", p, 1'b1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            if (n == 2) begin
                check("ready_low_busy", wr_ready, 1'b0);
                wr_en = 1'b1; wr_addr = 10'd5; wr_char = 8'h41; wr_color = 12'hFFF; wr_flash = 1'b0;
            end
            if (n == 500) clr_req = 1'b1;
            n++;
            step();
            wr_en = 1'b0;
            clr_req = 1'b0;
        end
        check("clear_cycles", n, 1008);
        probe(41, 0, p, c);
        check("cell5_blank", p, 1'b0);
        probe(43, 4, p, c);
        check("cell5_dropped_write", p, 1'b0);

        // Read-first collision and out-of-range write
        write_cell(29, 8'h41, 12'hF00, 1'b0);
        sx = 8'd10; sy = 9'd9;
        wr_en = 1'b1; wr_addr = 10'd29; wr_char = 8'h58; wr_color = 12'h0F0; wr_flash = 1'b0;
        step();
        wr_en = 1'b0;
        sx = 8'(OFF_X); sy = 9'(OFF_Y);
        step();
        check("collide_old", {R, G, B}, 12'hF00);
        probe(10, 9, p, c);
        check("collide_new", c, 12'h0F0);
        write_cell(1008, 8'hDB, 12'hFFF, 1'b0);
        probe(10, 9, p, c);
        check("oob_write_cell29", c, 12'h0F0);
        probe(4, 4, p, c);
        check("oob_write_cell0", p, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
